// File: rtl/redux_v_pkg.sv
// Shared Redux-V definitions: instruction width, NOP encoding and the
// instruction-memory state enumeration.
package redux_v_pkg;

    localparam int LARGURA_INSTR = 8;

    typedef logic [LARGURA_INSTR-1:0] instr_t;

    localparam instr_t NOP_INSTR = '0;

    typedef enum logic {
        LIMPANDO = 1'b0,
        PRONTO   = 1'b1
    } estado_mem_t;

endpackage

// File: rtl/banco_memoria_1r1w.sv
// Storage array with per-word loaded bits; synchronous 1R1W port pair,
// read-before-write on a same-address collision.
module banco_memoria_1r1w #(
    parameter int LARGURA = 8,
    parameter int PROFUNDIDADE = 256,
    parameter int LARGURA_END = $clog2(PROFUNDIDADE),
    parameter logic [LARGURA-1:0] NOP = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   re,
    input  logic                   rfora,
    input  logic [LARGURA_END-1:0] raddr,
    output logic [LARGURA-1:0]     rdata,
    output logic                   rcarregado,
    input  logic                   we,
    input  logic [LARGURA_END-1:0] waddr,
    input  logic [LARGURA-1:0]     wdata,
    input  logic                   wcarregado
);

    logic [LARGURA-1:0]      mem [PROFUNDIDADE];
    logic [PROFUNDIDADE-1:0] carregado;

    // The array has no reset; the post-reset sweep clears it instead.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr]       <= wdata;
            carregado[waddr] <= wcarregado;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata      <= NOP;
            rcarregado <= 1'b0;
        end else if (re) begin
            if (rfora) begin
                rdata      <= NOP;
                rcarregado <= 1'b0;
            end else begin
                rdata      <= mem[raddr];
                rcarregado <= carregado[raddr];
            end
        end
    end

endmodule

// File: rtl/memoria_instrucoes_sinc.sv
// Clocked instruction memory for the fetch stage: post-reset clear sweep,
// run-time load port and synchronous read with valid/end-of-program flags.
module memoria_instrucoes_sinc
    import redux_v_pkg::*;
#(
    parameter int LARGURA = LARGURA_INSTR,
    parameter int PROFUNDIDADE = 256,
    parameter int LARGURA_END = $clog2(PROFUNDIDADE),
    parameter logic [LARGURA-1:0] NOP = {LARGURA{1'b0}}
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ler,
    input  logic [LARGURA_END-1:0] endereco,
    output logic [LARGURA-1:0]     instrucao,
    output logic                   instrucao_valida,
    output logic                   fim_programa,
    input  logic                   escrever,
    input  logic [LARGURA_END-1:0] end_escrita,
    input  logic [LARGURA-1:0]     dado_escrita,
    output logic                   pronto
);

    localparam logic [LARGURA_END:0]   PROF_L = (LARGURA_END+1)'(PROFUNDIDADE);
    localparam logic [LARGURA_END-1:0] ULTIMO = LARGURA_END'(PROFUNDIDADE - 1);

    estado_mem_t            estado;
    logic [LARGURA_END-1:0] cnt;
    logic                   limpando;
    logic                   rd_ok;
    logic                   wr_ok;
    logic                   re;
    logic                   we;
    logic [LARGURA_END-1:0] waddr;
    logic [LARGURA-1:0]     wdata;
    logic [LARGURA-1:0]     rdata;
    logic                   rcarregado;

    assign limpando = (estado == LIMPANDO);
    assign rd_ok    = ({1'b0, endereco} < PROF_L);
    assign wr_ok    = ({1'b0, end_escrita} < PROF_L);

    assign re    = ler & pronto;
    assign we    = limpando | (escrever & pronto & wr_ok);
    assign waddr = limpando ? cnt : end_escrita;
    assign wdata = limpando ? NOP : dado_escrita;

    banco_memoria_1r1w #(
        .LARGURA      (LARGURA),
        .PROFUNDIDADE (PROFUNDIDADE),
        .LARGURA_END  (LARGURA_END),
        .NOP          (NOP)
    ) u_banco (
        .clk        (clk),
        .rst        (rst),
        .re         (re),
        .rfora      (~rd_ok),
        .raddr      (endereco),
        .rdata      (rdata),
        .rcarregado (rcarregado),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .wcarregado (~limpando)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado           <= LIMPANDO;
            cnt              <= '0;
            pronto           <= 1'b0;
            instrucao_valida <= 1'b0;
        end else begin
            unique case (estado)
                LIMPANDO: begin
                    cnt              <= cnt + 1'b1;
                    instrucao_valida <= 1'b0;
                    if (cnt == ULTIMO) begin
                        estado <= PRONTO;
                        pronto <= 1'b1;
                    end
                end
                PRONTO: begin
                    instrucao_valida <= ler;
                end
                default: begin
                    estado <= LIMPANDO;
                end
            endcase
        end
    end

    // Read registers hold between requests, so instrucao keeps its last value.
    assign instrucao    = rcarregado ? rdata : NOP;
    assign fim_programa = instrucao_valida & ~rcarregado;

endmodule

// File: tb/tb_memoria_instrucoes_sinc.sv
// Self-checking bench: a 256-word and a 100-word instance driven with directed
// and random traffic, checked against array-based reference models.
module tb_memoria_instrucoes_sinc;

    logic       clk = 1'b0;
    logic       rst;

    logic       a_ler, a_esc, a_val, a_fim, a_pronto;
    logic [7:0] a_end, a_ende, a_dado, a_instr;

    logic       b_ler, b_esc, b_val, b_fim, b_pronto;
    logic [6:0] b_end, b_ende;
    logic [7:0] b_dado, b_instr;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] ref_a [256];
    bit         ld_a  [256];
    logic [7:0] ref_b [100];
    bit         ld_b  [100];

    logic [7:0] hold_a;

    always #5 clk = ~clk;

    memoria_instrucoes_sinc #(.PROFUNDIDADE(256)) dut_a (
        .clk              (clk),
        .rst              (rst),
        .ler              (a_ler),
        .endereco         (a_end),
        .instrucao        (a_instr),
        .instrucao_valida (a_val),
        .fim_programa     (a_fim),
        .escrever         (a_esc),
        .end_escrita      (a_ende),
        .dado_escrita     (a_dado),
        .pronto           (a_pronto)
    );

    memoria_instrucoes_sinc #(.PROFUNDIDADE(100)) dut_b (
        .clk              (clk),
        .rst              (rst),
        .ler              (b_ler),
        .endereco         (b_end),
        .instrucao        (b_instr),
        .instrucao_valida (b_val),
        .fim_programa     (b_fim),
        .escrever         (b_esc),
        .end_escrita      (b_ende),
        .dado_escrita     (b_dado),
        .pronto           (b_pronto)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input int addr, input logic [7:0] d);
        a_esc  = 1'b1;
        a_ende = 8'(addr);
        a_dado = d;
        step();
        a_esc  = 1'b0;
        ref_a[addr] = d;
        ld_a[addr]  = 1'b1;
    endtask

    task automatic test_reset();
        logic [1:0] exp;
        rst = 1'b1;
        a_ler = 0; a_esc = 0; a_end = 0; a_ende = 0; a_dado = 0;
        b_ler = 0; b_esc = 0; b_end = 0; b_ende = 0; b_dado = 0;
        for (int i = 0; i < 256; i++) ld_a[i] = 0;
        for (int i = 0; i < 100; i++) ld_b[i] = 0;
        hold_a = 8'h00;
        #3;
        vectors++;
        if ({a_pronto, a_val, a_fim, a_instr} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %b required 0", {a_pronto, a_val, a_fim, a_instr});
        end
        @(negedge clk);
        rst = 1'b0;
        a_ler = 1'b1;
        a_end = 8'd5;
        for (int i = 1; i <= 256; i++) begin
            step();
            exp = {1'(i >= 256), 1'(i >= 100)};
            vectors++;
            if ({a_pronto, b_pronto, a_val} !== {exp, 1'b0}) begin
                miscompares++;
                $display("FAIL sweep cycle %0d: pronto_a/pronto_b/valid %b required %b",
                         i, {a_pronto, b_pronto, a_val}, {exp, 1'b0});
            end
        end
        a_ler = 1'b0;
        step();
        vectors++;
        if ({a_val, a_fim, a_instr} !== 10'd0) begin
            miscompares++;
            $display("FAIL sweep_idle: got %b required 0", {a_val, a_fim, a_instr});
        end
    endtask

    task automatic test_load_read();
        logic [7:0] w [4] = '{8'b10110000, 8'b10110101, 8'b10111010, 8'b10111111};
        for (int i = 0; i < 4; i++) write_a(i, w[i]);
        for (int i = 0; i < 4; i++) begin
            a_ler = 1'b1;
            a_end = 8'(i);
            step();
            vectors++;
            if ({a_val, a_fim, a_instr} !== {2'b10, w[i]}) begin
                miscompares++;
                $display("FAIL load_read @%0d: got %b required %b",
                         i, {a_val, a_fim, a_instr}, {2'b10, w[i]});
            end
        end
        a_ler = 1'b0;
        step();
        vectors++;
        if ({a_val, a_fim, a_instr} !== {2'b00, w[3]}) begin
            miscompares++;
            $display("FAIL read_hold: got %b required %b", {a_val, a_fim, a_instr}, {2'b00, w[3]});
        end
        hold_a = w[3];
    endtask

    task automatic test_unloaded();
        for (int i = 4; i < 40; i++) write_a(i, 8'($urandom));
        a_ler = 1'b1;
        a_end = 8'd40;
        step();
        a_ler = 1'b0;
        vectors++;
        if ({a_val, a_fim, a_instr} !== {2'b11, 8'h00}) begin
            miscompares++;
            $display("FAIL unloaded @40: got %b required %b", {a_val, a_fim, a_instr}, {2'b11, 8'h00});
        end
        hold_a = 8'h00;
    endtask

    task automatic test_collision();
        write_a(7, 8'b00110100);
        a_esc = 1'b1; a_ende = 8'd7; a_dado = 8'b11001000;
        a_ler = 1'b1; a_end = 8'd7;
        step();
        a_esc = 1'b0;
        ref_a[7] = 8'b11001000;
        vectors++;
        if ({a_val, a_fim, a_instr} !== {2'b10, 8'b00110100}) begin
            miscompares++;
            $display("FAIL collision_old: got %b required %b",
                     {a_val, a_fim, a_instr}, {2'b10, 8'b00110100});
        end
        step();
        vectors++;
        if ({a_val, a_fim, a_instr} !== {2'b10, 8'b11001000}) begin
            miscompares++;
            $display("FAIL collision_new: got %b required %b",
                     {a_val, a_fim, a_instr}, {2'b10, 8'b11001000});
        end
        // unloaded word written and read in the same cycle still reads as unloaded
        a_esc = 1'b1; a_ende = 8'd200; a_dado = 8'h5A;
        a_end = 8'd200;
        step();
        a_esc = 1'b0;
        ref_a[200] = 8'h5A;
        ld_a[200]  = 1'b1;
        vectors++;
        if ({a_val, a_fim, a_instr} !== {2'b11, 8'h00}) begin
            miscompares++;
            $display("FAIL collision_unloaded: got %b required %b",
                     {a_val, a_fim, a_instr}, {2'b11, 8'h00});
        end
        step();
        a_ler = 1'b0;
        vectors++;
        if ({a_val, a_fim, a_instr} !== {2'b10, 8'h5A}) begin
            miscompares++;
            $display("FAIL collision_unloaded_next: got %b required %b",
                     {a_val, a_fim, a_instr}, {2'b10, 8'h5A});
        end
        hold_a = 8'h5A;
    endtask

    task automatic test_back_to_back();
        int         ra, wa;
        bit         l, e;
        bit         ef;
        logic [7:0] d;
        for (int n = 0; n < 300; n++) begin
            l  = 1'($urandom_range(0, 1));
            e  = 1'($urandom_range(0, 1));
            ra = $urandom_range(0, 255);
            wa = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, 255);
            d  = 8'($urandom);
            ef = 1'b0;
            if (l) begin
                ef     = !ld_a[ra];
                hold_a = ld_a[ra] ? ref_a[ra] : 8'h00;
            end
            a_ler = l; a_end = 8'(ra);
            a_esc = e; a_ende = 8'(wa); a_dado = d;
            step();
            if (e) begin
                ref_a[wa] = d;
                ld_a[wa]  = 1'b1;
            end
            vectors++;
            if ({a_val, a_fim, a_instr} !== {l, ef, hold_a}) begin
                miscompares++;
                $display("FAIL b2b #%0d rd@%0d: got %b required %b",
                         n, ra, {a_val, a_fim, a_instr}, {l, ef, hold_a});
            end
        end
        a_ler = 1'b0;
        a_esc = 1'b0;
    endtask

    task automatic test_out_of_range();
        logic [7:0] exp;
        for (int i = 0; i < 100; i++) begin
            ref_b[i] = 8'($urandom);
            if (ref_b[i] == 8'h00) ref_b[i] = 8'h01;
            ld_b[i] = ($urandom_range(0, 3) != 0);
            if (i == 99) ld_b[i] = 1'b1;
            b_esc = ld_b[i]; b_ende = 7'(i); b_dado = ref_b[i];
            step();
        end
        b_esc = 1'b1; b_ende = 7'd120; b_dado = 8'hFF;
        step();
        b_ende = 7'd100; b_dado = 8'hEE;
        step();
        b_esc = 1'b0;
        for (int i = 0; i < 100; i++) begin
            b_ler = 1'b1; b_end = 7'(i);
            step();
            exp = ld_b[i] ? ref_b[i] : 8'h00;
            vectors++;
            if ({b_val, b_fim, b_instr} !== {1'b1, !ld_b[i], exp}) begin
                miscompares++;
                $display("FAIL range_word @%0d: got %b required %b",
                         i, {b_val, b_fim, b_instr}, {1'b1, !ld_b[i], exp});
            end
        end
        b_end = 7'd120;
        step();
        vectors++;
        if ({b_val, b_fim, b_instr} !== {2'b11, 8'h00}) begin
            miscompares++;
            $display("FAIL range_rd120: got %b required %b", {b_val, b_fim, b_instr}, {2'b11, 8'h00});
        end
        b_end = 7'd100;
        step();
        b_ler = 1'b0;
        vectors++;
        if ({b_val, b_fim, b_instr} !== {2'b11, 8'h00}) begin
            miscompares++;
            $display("FAIL range_rd100: got %b required %b", {b_val, b_fim, b_instr}, {2'b11, 8'h00});
        end
    endtask

    task automatic test_rst_mid();
        a_ler = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_end = 8'(i);
            step();
        end
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        if ({a_pronto, a_val, a_fim, a_instr} !== 11'd0) begin
            miscompares++;
            $display("FAIL rst_async: got %b required 0", {a_pronto, a_val, a_fim, a_instr});
        end
        @(negedge clk);
        rst = 1'b0;
        a_end = 8'd0;
        for (int i = 1; i <= 256; i++) begin
            step();
            vectors++;
            if ({a_pronto, a_val} !== {1'(i >= 256), 1'b0}) begin
                miscompares++;
                $display("FAIL resweep cycle %0d: pronto/valid %b required %b",
                         i, {a_pronto, a_val}, {1'(i >= 256), 1'b0});
            end
        end
        for (int i = 0; i < 256; i++) begin
            a_end = 8'(i);
            step();
            vectors++;
            if ({a_val, a_fim, a_instr} !== {2'b11, 8'h00}) begin
                miscompares++;
                $display("FAIL cleared @%0d: got %b required %b",
                         i, {a_val, a_fim, a_instr}, {2'b11, 8'h00});
            end
        end
        a_ler = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_read();
        test_unloaded();
        test_collision();
        test_back_to_back();
        test_out_of_range();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
